// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode encodings, FSM states and
// the opcode legality check used to raise the error flag.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic op_supported(logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: 8-bit unsigned operands, 16-bit result.
// Unsupported opcodes produce zero; flagging them is left to the caller.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result
);

    always_comb begin
        result = 16'h0000;
        case (op)
            OP_ADD:  result = {8'h00, a} + {8'h00, b};
            OP_SUB:  result = {8'h00, a} - {8'h00, b};
            OP_MUL:  result = {8'h00, a} * {8'h00, b};
            default: result = 16'h0000;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, one command in flight:
// accept in IDLE, compute in EXEC, hold the registered result in RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][3:0] req_opcode,
    input  logic [NUM_REQ-1:0][7:0] req_a,
    input  logic [NUM_REQ-1:0][7:0] req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [15:0]             rsp_result,
    output logic                    rsp_err,
    output logic                    busy
);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;
    logic        grant;
    logic [15:0] alu_result;

    alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        // A lone requester wins outright; a tie goes to the prio pointer.
        grant     = (req_valid == 2'b11) ? prio_q : req_valid[1];

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    owner_d          = grant;
                    op_d             = req_opcode[grant];
                    a_d              = req_a[grant];
                    b_d              = req_b[grant];
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                err_d    = !op_supported(op_q);
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= 4'h0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            result_q <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Result and error hold their last value outside RESP; rsp_valid qualifies them.
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued on each accepted
// command and matched against responses as they complete.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0][3:0] req_opcode = '0;
    logic [1:0][7:0] req_a = '0;
    logic [1:0][7:0] req_b = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = 2'b11;
    logic [15:0]     rsp_result;
    logic            rsp_err;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] sb[$];      // {owner, err, result}
    logic        grants[$];
    logic        mon_w;
    logic [17:0] mon_e;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [15:0] aa, bb;
        aa = {8'h00, a};
        bb = {8'h00, b};
        if (op == 4'h1) return {1'b0, aa + bb};
        if (op == 4'h2) return {1'b0, aa - bb};
        if (op == 4'h3) return {1'b0, aa * bb};
        return {1'b1, 16'h0000};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if ((req_valid & req_ready) != 2'b00) begin
                mon_w = req_ready[1];
                sb.push_back({mon_w, model(req_opcode[mon_w], req_a[mon_w], req_b[mon_w])});
                grants.push_back(mon_w);
            end
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("rsp_owner_onehot", {30'd0, rsp_valid}, mon_e[17] ? 32'd2 : 32'd1);
                    check_eq("rsp_result", {16'd0, rsp_result}, {16'd0, mon_e[15:0]});
                    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e[16]});
                end
            end
        end
    end

    // Drive one command; returns at posedge+1 after the accepting cycle.
    task automatic send(input int r, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit keep, output int waits);
        @(posedge clk);
        #1;
        req_opcode[r] = op;
        req_a[r]      = a;
        req_b[r]      = b;
        req_valid[r]  = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req_ready[r]) break;
            waits++;
            if (waits > 100) begin
                check_eq("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        sb.delete();
        grants.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int w;
    logic got_grant;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_ready", {30'd0, req_ready}, 32'd0);

        // Single op with latency: accept N, EXEC N+1, rsp_valid in N+2
        send(0, OP_ADD, 8'hFF, 8'hFF, 0, w);
        check_eq("single_ready_same_cycle", w, 32'd0);
        @(negedge clk);
        check_eq("single_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_eq("single_exec_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check_eq("single_rsp_result", {16'd0, rsp_result}, 32'h01FE);
        check_eq("single_rsp_err", {31'd0, rsp_err}, 32'd0);
        drain();

        // Arithmetic edges
        send(0, OP_SUB, 8'd3, 8'd5, 0, w);
        drain();
        check_eq("sub_wrap", {16'd0, rsp_result}, 32'hFFFE);
        send(1, OP_MUL, 8'd255, 8'd255, 0, w);
        drain();
        check_eq("mul_max", {16'd0, rsp_result}, 32'hFE01);
        send(0, 4'h7, 8'd12, 8'd34, 0, w);
        drain();
        check_eq("bad_op_result", {16'd0, rsp_result}, 32'h0000);
        check_eq("bad_op_err", {31'd0, rsp_err}, 32'd1);

        // Back-pressure on requester 1 while requester 0 waits
        rsp_ready = 2'b01;
        send(1, OP_ADD, 8'd10, 8'd20, 0, w);
        req_opcode[0] = OP_MUL;
        req_a[0]      = 8'd2;
        req_b[0]      = 8'd3;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        check_eq("bp_exec_ready", {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            check_eq("bp_rsp_result", {16'd0, rsp_result}, 32'd30);
            check_eq("bp_req_ready", {30'd0, req_ready}, 32'd0);
            check_eq("bp_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        got_grant = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                got_grant = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check_eq("bp_grant0_after", {31'd0, got_grant}, 32'd1);
        drain();

        // Fairness from prio=0 with both requesters always valid
        do_reset();
        fork
            begin
                int wa;
                for (int i = 0; i < 4; i++) send(0, OP_ADD, 8'(i + 1), 8'd7, 1, wa);
                req_valid[0] = 1'b0;
            end
            begin
                int wb;
                for (int i = 0; i < 4; i++) send(1, OP_SUB, 8'd100, 8'(i * 9), 1, wb);
                req_valid[1] = 1'b0;
            end
        join
        drain();
        check_eq("fair_count", grants.size(), 32'd8);
        for (int i = 0; i < grants.size(); i++)
            check_eq("fair_order", {31'd0, grants[i]}, i % 2);

        // Reset during EXEC drops the in-flight command
        send(0, OP_ADD, 8'd5, 8'd6, 0, w);
        check_eq("midrst_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_eq("midrst_rsp_result", {16'd0, rsp_result}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("midrst_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        send(0, OP_ADD, 8'd1, 8'd2, 0, w);
        drain();
        check_eq("post_rst_add", {16'd0, rsp_result}, 32'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU (add/sub/mul, 8-bit operands, 16-bit result) between two requesters. Each requester issues opcode/operand commands over a valid/ready handshake. The block grants requesters round-robin, registers the operands, runs the ALU, registers the result and returns it to the owning requester over a second valid/ready handshake. It sits between command sources (e.g. a sequencer and a host port) and the shared ALU instance.

## Interface
- NUM_REQ, 2, number of requesters; fixed at 2, and other values are unsupported.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  [1:0]  command valid, one bit per requester.
- req_ready  output  [1:0]  command accepted; one-hot or zero.
- req_opcode  input  [1:0][3:0]  per-requester opcode.
- req_a, req_b  input  [1:0][7:0]  per-requester operands.
- rsp_valid  output  [1:0]  result valid for that requester; one-hot or zero.
- rsp_ready  input  [1:0]  requester accepts result.
- rsp_result  output  [15:0]  result, shared by both requesters.
- rsp_err  output  1  opcode was not ADD/SUB/MUL.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Opcodes**
  - 4'h1 ADD: {8'h0,a}+{8'h0,b}.
  - 4'h2 SUB: {8'h0,a}-{8'h0,b}, wrapping in 16 bits (3-5 = 16'hFFFE).
  - 4'h3 MUL: a*b, unsigned, full 16 bits.
  - Any other opcode: result 16'h0000 and rsp_err=1.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - If any req_valid is high, select one requester and assert its req_ready combinationally in the same cycle.
  - The transfer (valid&&ready) captures opcode, a, b and owner into registers; next state is EXEC.
  - If no request is valid, stay in IDLE with req_ready=0.
- **Arbitration**
  - Round-robin via a 1-bit pointer `prio`.
  - If only one requester is valid, it wins.
  - If both are valid, the requester indexed by `prio` wins.
  - `prio` toggles to the non-winner when the response completes.
- **EXEC**
  - The ALU computes from the registered operands.
  - result_q and err_q are loaded; next state is RESP.
- **RESP**
  - rsp_valid[owner]=1; rsp_result=result_q; rsp_err=err_q.
  - Hold until rsp_ready[owner]=1, then go to IDLE and update `prio`.
  - rsp_ready of the non-owner is ignored.
- **Request rules**
  - req_ready stays 0 outside IDLE; a valid request waits and must be held stable by the requester.
  - One command in flight at a time; there is no queueing.

## Timing
- **Reset values:** state=IDLE, prio=0, req_ready=0, rsp_valid=0, rsp_result=16'h0000, rsp_err=0, busy=0.
- **Latency**
  - Accept in cycle N; rsp_valid rises at the clock edge ending cycle N+1 (visible in cycle N+2).
  - Minimum occupancy is 3 cycles per command.
  - Back-to-back: the next accept can occur in the IDLE cycle after the RESP handshake.
- **Response outputs**
  - rsp_result and rsp_err are stable throughout RESP.
  - Outside RESP they hold their last value; only rsp_valid qualifies them.
- **Simultaneous requests:** both valid in IDLE with prio=0 gives requester 0 first, then requester 1 next (prio=1).
- **Reset mid-operation:** reset in EXEC or RESP aborts asynchronously. The FSM returns to IDLE and outputs take their reset values; the in-flight command is dropped with no response.
- **Back-pressure:** if rsp_ready stays 0, the FSM remains in RESP indefinitely and busy stays 1.

## Structure
- **Shared package alu_pkg:**
  - opcode constants OP_ADD=4'h1, OP_SUB=4'h2, OP_MUL=4'h3;
  - the typedef enum for the FSM states {IDLE, EXEC, RESP}.
- **Sub-module:** instantiate the existing `alu` module unchanged as the datapath, fed from the registered opcode/a/b.
- **Error flag:** computed in alu_arbiter from the registered opcode, not inside the ALU.

## Test plan
- **Reset:** apply rst_n=0 → all outputs 0 and busy=0; after release, with no requests, the FSM stays idle.
- **Single op:** req0 ADD a=8'hFF, b=8'hFF → req_ready[0] in the same cycle; rsp_valid[0] two cycles later with rsp_result=16'h01FE, rsp_err=0.
- **Arithmetic edges:**
  - SUB 3,5 → 16'hFFFE.
  - MUL 255,255 → 16'hFE01.
  - Opcode 4'h7 → 16'h0000 with rsp_err=1.
- **Fairness:** both valid continuously with alternating commands → grants alternate 0,1,0,1 starting with 0, and each response goes only to its owner.
- **Back-pressure:** hold rsp_ready[1]=0 for 5 cycles while req0 is valid → rsp_valid[1] and rsp_result hold stable, req_ready[0]=0 throughout; req0 is granted after the RESP handshake.
- **Mid-op reset:** assert rst_n=0 during EXEC → rsp_valid never asserts for that command; after release, a new ADD 1,2 returns 16'h0003.
